// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encoding and counter width for the data-RAM arbiter.
package dmem_arbiter_pkg;
  localparam int CW = 4;
  typedef enum logic {S_CPU = 1'b0, S_DBG = 1'b1} state_t;
endpackage

// File: rtl/dmem_arb_fsm.sv
// dmem_arb_fsm: CPU-priority / locked-burst arbitration state, starvation and burst counters, grants.
module dmem_arb_fsm
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 3,
  parameter int MAX_BURST  = 4
) (
  input  logic CLK,
  input  logic Clrn,
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic dbg_lock,
  output logic dbg_gnt,
  output logic cpu_stall
);
  state_t state;
  logic [CW-1:0] starve_cnt, burst_cnt;
  logic burst_end;
  always_comb begin
    dbg_gnt   = Clrn & dbg_req & (state == S_DBG | ~cpu_req | starve_cnt == CW'(STARVE_LIM));
    cpu_stall = cpu_req & dbg_gnt;
    burst_end = (burst_cnt + CW'(1)) == CW'(MAX_BURST);
  end
  // A one-grant burst limit never enters S_DBG, so the CPU regains priority right away.
  always_ff @(posedge CLK or negedge Clrn) begin
    if (!Clrn) begin
      state      <= S_CPU;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else if (state == S_CPU) begin
      starve_cnt <= (dbg_gnt | ~dbg_req) ? '0 : starve_cnt + CW'(1);
      if (dbg_gnt & dbg_lock & (MAX_BURST > 1)) begin
        state     <= S_DBG;
        burst_cnt <= CW'(1);
      end
    end else begin
      starve_cnt <= '0;
      if (~dbg_lock | ~dbg_req | burst_end) begin
        state     <= S_CPU;
        burst_cnt <= '0;
      end else begin
        burst_cnt <= burst_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the MEM stage and a debug/loader port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 3,
  parameter int MAX_BURST  = 4
) (
  input  logic          CLK,
  input  logic          Clrn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_lock,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  dmem_arb_fsm #(.STARVE_LIM(STARVE_LIM), .MAX_BURST(MAX_BURST)) u_fsm (
    .CLK      (CLK),
    .Clrn     (Clrn),
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .dbg_lock (dbg_lock),
    .dbg_gnt  (dbg_gnt),
    .cpu_stall(cpu_stall)
  );
  // The CPU only reaches the RAM when debug is not granted, so a denied store never writes.
  always_comb begin
    cpu_rdata = ram_rdata;
    ram_addr  = dbg_gnt ? dbg_addr : cpu_addr;
    ram_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    ram_we    = dbg_gnt ? dbg_we : Clrn & cpu_req & cpu_we;
  end
  always_ff @(posedge CLK or negedge Clrn) begin
    if (!Clrn) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (dbg_gnt & ~dbg_we) dbg_rdata <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the data-RAM arbiter with a debug-read scoreboard.
module tb_dmem_arbiter;
  logic        CLK = 1'b0, Clrn = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_lock = 0, dbg_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic [31:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        cpu_stall, dbg_gnt, dbg_rvalid, ram_we;
  logic [31:0] mem [0:255];
  logic [31:0] sb [$];
  int total = 0, bad = 0, w30 = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter dut (
    .CLK(CLK), .Clrn(Clrn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
    if (ram_we && ram_addr == 32'h30) w30 <= w30 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (Clrn && dbg_rvalid) begin
      if (sb.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
      else chk("dbg_rdata", dbg_rdata, sb.pop_front());
    end
  end

  initial begin
    dbg_req = 1; dbg_we = 1; cpu_req = 0;
    #3;
    chk("rst_stall", {31'd0, cpu_stall}, 0);
    chk("rst_gnt", {31'd0, dbg_gnt}, 0);
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_rvalid", {31'd0, dbg_rvalid}, 0);
    chk("rst_rdata", dbg_rdata, 0);
    @(negedge CLK); Clrn = 1; dbg_req = 0; dbg_we = 0;
    tick();
    // CPU only
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #3;
    chk("cpu_wr_stall", {31'd0, cpu_stall}, 0);
    chk("cpu_wr_we", {31'd0, ram_we}, 1);
    tick();
    cpu_we = 0;
    #3;
    chk("cpu_rd_stall", {31'd0, cpu_stall}, 0);
    chk("cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();
    // debug write then read in idle slots
    cpu_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
    #3;
    chk("dbg_wr_gnt", {31'd0, dbg_gnt}, 1);
    chk("dbg_wr_addr", ram_addr, 32'h20);
    chk("dbg_wr_we", {31'd0, ram_we}, 1);
    tick();
    dbg_we = 0;
    #3;
    chk("dbg_rd_gnt", {31'd0, dbg_gnt}, 1);
    sb.push_back(32'h12345678);
    tick();
    dbg_req = 0;
    #3;
    chk("dbg_rvalid_1", {31'd0, dbg_rvalid}, 1);
    tick();
    #3;
    chk("dbg_rvalid_0", {31'd0, dbg_rvalid}, 0);
    tick();
    // starvation: debug forced every fourth cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    for (int i = 0; i < 8; i++) begin
      #3;
      chk($sformatf("starve_gnt%0d", i), {31'd0, dbg_gnt}, {31'd0, i % 4 == 3});
      chk($sformatf("starve_stall%0d", i), {31'd0, cpu_stall}, {31'd0, i % 4 == 3});
      if (i % 4 == 3) sb.push_back(32'h12345678);
      else chk($sformatf("starve_cpu_rdata%0d", i), cpu_rdata, 32'hDEADBEEF);
      tick();
    end
    cpu_req = 0; dbg_req = 0;
    tick();
    // locked burst: forced slot plus three more, then CPU regains the RAM
    cpu_req = 1; dbg_req = 1; dbg_lock = 1;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk($sformatf("burst_gnt%0d", i), {31'd0, dbg_gnt}, {31'd0, i >= 3 && i <= 6});
      chk($sformatf("burst_stall%0d", i), {31'd0, cpu_stall}, {31'd0, i >= 3 && i <= 6});
      if (i >= 3 && i <= 6) sb.push_back(32'h12345678);
      tick();
    end
    cpu_req = 0; dbg_req = 0; dbg_lock = 0;
    tick();
    // stalled store: denied while debug writes 0x40, lands once afterwards
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'hA5A5A5A5;
    tick(); tick(); tick();
    cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFE0001;
    #3;
    chk("ss_stall", {31'd0, cpu_stall}, 1);
    chk("ss_ram_addr", ram_addr, 32'h40);
    chk("ss_ram_wdata", ram_wdata, 32'hA5A5A5A5);
    chk("ss_ram_we", {31'd0, ram_we}, 1);
    tick();
    dbg_req = 0;
    #3;
    chk("ss_retry_stall", {31'd0, cpu_stall}, 0);
    chk("ss_retry_addr", ram_addr, 32'h30);
    tick();
    cpu_we = 0;
    #3;
    chk("ss_readback", cpu_rdata, 32'hCAFE0001);
    chk("ss_write_count", w30, 1);
    tick();
    cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
    sb.push_back(32'hA5A5A5A5);
    tick();
    dbg_req = 0;
    tick(); tick();
    // async reset in the middle of a burst
    dbg_req = 1; dbg_lock = 1; dbg_we = 0; dbg_addr = 32'h20;
    #3;
    chk("ar_gnt_a", {31'd0, dbg_gnt}, 1);
    sb.push_back(32'h12345678);
    tick();
    cpu_req = 1;
    #3;
    chk("ar_burst_stall", {31'd0, cpu_stall}, 1);
    #2;
    Clrn = 0;
    #1;
    chk("ar_rvalid", {31'd0, dbg_rvalid}, 0);
    chk("ar_stall", {31'd0, cpu_stall}, 0);
    chk("ar_gnt", {31'd0, dbg_gnt}, 0);
    Clrn = 1;
    #1;
    chk("ar_post_gnt", {31'd0, dbg_gnt}, 0);
    chk("ar_post_stall", {31'd0, cpu_stall}, 0);
    tick();
    cpu_req = 0; dbg_req = 0; dbg_lock = 0;
    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between the pipeline MEM stage (M_ALUout address, M_busB write data, M_MemWr) and a debug/loader port used to preload and inspect data memory.
- CPU has priority by default; a starvation counter and a bounded burst mode guarantee debug progress.
- Sits between the Ex_Mem outputs and DataRAM. Drives a stall that freezes PC, IF_ID, ID_EX, Ex_Mem and Mem_Wr while the CPU is denied.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIM, 3, consecutive denied debug-request cycles before debug is forced a slot (1..15)
- MAX_BURST, 4, maximum consecutive debug grants in a locked burst (1..15)

Ports:
- CLK  in  1  clock; RAM writes and all state update on the rising edge
- Clrn  in  1  asynchronous active-low reset
- cpu_req  in  1  MEM stage needs RAM this cycle (M_MemWr | M_MemtoReg)
- cpu_we  in  1  write when 1
- cpu_addr  in  AW  byte address
- cpu_wdata  in  DW  store data
- cpu_rdata  out  DW  load data, combinational from ram_rdata
- cpu_stall  out  1  1 = CPU access denied this cycle; pipeline must hold
- dbg_req  in  1  debug access request; held with its fields until granted
- dbg_lock  in  1  request a burst of back-to-back debug grants
- dbg_we  in  1  write when 1
- dbg_addr  in  AW  byte address
- dbg_wdata  in  DW  write data
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rvalid  out  1  registered; 1 the cycle after a granted debug read
- dbg_rdata  out  DW  registered read data, valid with dbg_rvalid
- ram_we  out  1  to DataRAM WE
- ram_addr  out  AW  to DataRAM Address
- ram_wdata  out  DW  to DataRAM DataIn
- ram_rdata  in  DW  from DataRAM DataOut (combinational read)

Behaviour:
- Reset (Clrn=0, async): state=S_CPU, starve_cnt=0, burst_cnt=0, dbg_rvalid=0, dbg_rdata=0.
- During reset: cpu_stall=0, dbg_gnt=0, ram_we=0.
- States:
  - S_CPU: CPU priority.
  - S_DBG: locked debug burst.
- Grant decision, combinational, each cycle:
  - S_CPU, cpu_req=0, dbg_req=1: dbg granted; cpu_stall=0.
  - S_CPU, cpu_req=1, dbg_req=1, starve_cnt<STARVE_LIM: CPU granted; starve_cnt++; dbg_gnt=0.
  - S_CPU, cpu_req=1, dbg_req=1, starve_cnt==STARVE_LIM: dbg granted; cpu_stall=1; starve_cnt cleared.
  - S_DBG: dbg granted whenever dbg_req=1; cpu_stall=cpu_req.
  - No requests: ram_we=0, ram_addr=cpu_addr.
- Muxing: the granted port drives ram_addr, ram_wdata and ram_we (req & we). cpu_rdata=ram_rdata at all times.
- starve_cnt clears on any debug grant or when dbg_req=0.
- Transitions:
  - S_CPU to S_DBG: on a debug grant with dbg_lock=1; burst_cnt=1.
  - In S_DBG: each grant increments burst_cnt.
  - S_DBG to S_CPU: when dbg_lock=0, or dbg_req=0, or burst_cnt reaches MAX_BURST after a grant. burst_cnt cleared; starve_cnt=0.
  - After a MAX_BURST exit, the CPU keeps priority for at least one cycle, even if lock is still high.
- Reads: a granted debug read (dbg_gnt & ~dbg_we) registers ram_rdata into dbg_rdata; dbg_rvalid=1 for exactly one cycle. Otherwise dbg_rvalid=0 and dbg_rdata holds.
- A stalled CPU store must not write. ram_we reflects only the granted port.
- Latency: CPU access 0 extra cycles when granted. Debug write completes at the grant edge. Debug read data arrives 1 cycle after grant.
- Address width: full AW passed through; no alignment checks. DataRAM word-indexes internally.

Decomposition:
- Shared package holds the state encoding (S_CPU=1'b0, S_DBG=1'b1) and counter widths (4 bits, sized for limits up to 15).
- One natural sub-module, dmem_arb_fsm: state register, starve_cnt and burst_cnt, grant outputs.
- The top module keeps the address/data muxes and the dbg_rdata/dbg_rvalid registers.

Test Plan:
- CPU only: cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF; then a read of 0x10. Expect cpu_stall=0 both cycles and cpu_rdata=0xDEADBEEF.
- Debug idle slot: dbg write 0x20=0x12345678 with cpu_req=0. Expect dbg_gnt=1 that cycle. Then a debug read of 0x20: dbg_rvalid=1 and dbg_rdata=0x12345678 the next cycle.
- Starvation with STARVE_LIM=3: cpu_req and dbg_req held high. Expect CPU granted cycles 0-2. Cycle 3: dbg_gnt=1, cpu_stall=1. Pattern repeats every 4 cycles.
- Burst with MAX_BURST=4: dbg_lock=1 and both requests held. Expect 4 consecutive dbg_gnt with cpu_stall=1, then at least one cycle with cpu_stall=0, dbg_gnt=0.
- Stalled store: cpu store to 0x30 denied during a debug grant. Expect ram_we to carry only the debug write. The 0x30 store lands on the next granted cycle; a later read confirms a single write.
- Async reset mid-burst: drop Clrn between clock edges while in S_DBG. Expect immediate dbg_rvalid=0, cpu_stall=0, dbg_gnt=0. After release, state is S_CPU.
